// File: rtl/assembler_pkg.sv
// Shared types and constants for the serial word assembler.
// Imported by the shifter and the top level.
package assembler_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/word_shifter.sv
// Partial-word shift register and bit counter.
// word_done strobes in the cycle whose edge captures the last bit.
module word_shifter
    import assembler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          shift_en,
    input  logic                          bit_in,
    output logic [cnt_width(WIDTH)-1:0]   bit_count,
    output logic [WIDTH-1:0]              next_word,
    output logic                          word_done
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] base_p;
    logic [CW-1:0]    base_c;

    // A frame_start bit is the first bit of a fresh word.
    always_comb begin
        base_p = clear ? '0 : partial;
        base_c = clear ? '0 : bit_count;
        if (MSB_FIRST)
            next_word = {base_p[WIDTH-2:0], bit_in};
        else
            next_word = {bit_in, base_p[WIDTH-1:1]};
        word_done = shift_en && (base_c == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial   <= '0;
            bit_count <= '0;
        end else if (shift_en) begin
            partial   <= word_done ? '0 : next_word;
            bit_count <= word_done ? '0 : base_c + CW'(1);
        end else if (clear) begin
            partial   <= '0;
            bit_count <= '0;
        end
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Collects framed serial bits into words on a valid/ready port.
// Words that find the output busy are dropped and flagged.
module serial_word_assembler
    import assembler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic [WIDTH-1:0]              word,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic [cnt_width(WIDTH)-1:0]   bit_count
);

    state_t           state_q;
    state_t           state_d;
    logic             shift_en;
    logic             word_done;
    logic [WIDTH-1:0] next_word;
    logic             out_free;
    logic             ovr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        if (frame_start)
            state_d = COLLECT;
        if (bit_valid && (frame_start || state_q == COLLECT))
            shift_en = 1'b1;
    end

    word_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (frame_start),
        .shift_en  (shift_en),
        .bit_in    (bit_in),
        .bit_count (bit_count),
        .next_word (next_word),
        .word_done (word_done)
    );

    assign out_free = !word_valid || word_ready;
    assign ovr_set  = word_done && !out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            word_valid <= 1'b0;
        end else if (word_done && out_free) begin
            word       <= next_word;
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overrun <= 1'b0;
        else if (ovr_set)     overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler, both bit orders side by side.
// A bit-queue model predicts words, valid, overrun and bit_count.
module tb_serial_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        word_ready = 1'b0;
    logic        clr_overrun = 1'b0;
    logic [15:0] word_m, word_l;
    logic        val_m, val_l, ovr_m, ovr_l;
    logic [4:0]  cnt_m, cnt_l;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit          m_frame;
    int          m_bits[$];
    logic [15:0] m_wm, m_wl;
    bit          m_valid, m_ovr;

    always #5 clk = ~clk;

    serial_word_assembler #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .bit_in(bit_in), .bit_valid(bit_valid), .word(word_m),
        .word_valid(val_m), .word_ready(word_ready), .overrun(ovr_m),
        .clr_overrun(clr_overrun), .bit_count(cnt_m)
    );

    serial_word_assembler #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .bit_in(bit_in), .bit_valid(bit_valid), .word(word_l),
        .word_valid(val_l), .word_ready(word_ready), .overrun(ovr_l),
        .clr_overrun(clr_overrun), .bit_count(cnt_l)
    );

    task automatic model_reset();
        m_frame = 0;
        m_bits.delete();
        m_wm = '0;
        m_wl = '0;
        m_valid = 0;
        m_ovr = 0;
    endtask

    task automatic model_step(input bit f, v, b, r, c);
        bit consumed, done, set;
        logic [15:0] wm, wl;
        consumed = m_valid && r;
        done = 0;
        set = 0;
        wm = '0;
        wl = '0;
        if (f) begin
            m_frame = 1;
            m_bits.delete();
        end
        if (v && m_frame) begin
            m_bits.push_back(int'(b));
            if (m_bits.size() == 16) begin
                done = 1;
                for (int i = 0; i < 16; i++) begin
                    wm[15-i] = m_bits[i][0];
                    wl[i]    = m_bits[i][0];
                end
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_wm = wm;
                m_wl = wl;
                m_valid = 1;
            end else begin
                set = 1;
            end
        end else if (consumed) begin
            m_valid = 0;
        end
        if (set) m_ovr = 1;
        else if (c) m_ovr = 0;
    endtask

    task automatic tick(input bit f, v, b, r, c);
        frame_start = f;
        bit_valid = v;
        bit_in = b;
        word_ready = r;
        clr_overrun = c;
        model_step(f, v, b, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input bit r);
        for (int i = 0; i < 16; i++)
            tick(0, 1, w[15-i], r, 0);
    endtask

    task automatic apply_reset();
        frame_start = 0;
        bit_valid = 0;
        bit_in = 0;
        word_ready = 0;
        clr_overrun = 0;
        rst_n = 0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({val_m, val_l, ovr_m, ovr_l} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000",
                     {val_m, val_l, ovr_m, ovr_l});
        end
        n_cmp++;
        if (word_m !== 16'h0 || word_l !== 16'h0) begin
            n_err++;
            $display("FAIL reset_word: got %h/%h want 0000", word_m, word_l);
        end
        n_cmp++;
        if (cnt_m !== 5'd0 || cnt_l !== 5'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d/%0d want 0", cnt_m, cnt_l);
        end
        release_reset();
    endtask

    task automatic test_idle_ignore();
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 1'($urandom), 1'($urandom), 0);
            if (val_m || val_l || cnt_m != 0 || cnt_l != 0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL idle_ignore: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_msb_first();
        tick(1, 0, 0, 1, 0);
        send_word(16'hA5C3, 1);
        n_cmp++;
        if (val_m !== 1'b1 || word_m !== 16'hA5C3) begin
            n_err++;
            $display("FAIL msb_word: got v=%b %h want v=1 a5c3", val_m, word_m);
        end
        n_cmp++;
        if (word_l !== m_wl) begin
            n_err++;
            $display("FAIL msb_lsbdut: got %h want %h", word_l, m_wl);
        end
        tick(0, 0, 0, 1, 0);
        n_cmp++;
        if (val_m !== 1'b0) begin
            n_err++;
            $display("FAIL msb_drop: got v=%b want 0", val_m);
        end
    endtask

    task automatic test_lsb_first();
        tick(1, 0, 0, 1, 0);
        send_word(16'h8000, 1);
        n_cmp++;
        if (val_l !== 1'b1 || word_l !== 16'h0001) begin
            n_err++;
            $display("FAIL lsb_word: got v=%b %h want v=1 0001", val_l, word_l);
        end
        n_cmp++;
        if (word_m !== 16'h8000) begin
            n_err++;
            $display("FAIL lsb_msbdut: got %h want 8000", word_m);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_overrun();
        tick(1, 0, 0, 0, 0);
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        n_cmp++;
        if (word_m !== 16'h1111 || val_m !== 1'b1 || ovr_m !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_hold: got %h v=%b o=%b want 1111 v=1 o=1",
                     word_m, val_m, ovr_m);
        end
        n_cmp++;
        if (word_l !== m_wl || ovr_l !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_hold_l: got %h o=%b want %h o=1",
                     word_l, ovr_l, m_wl);
        end
        tick(0, 0, 0, 0, 1);
        n_cmp++;
        if (ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: got %b%b want 00", ovr_m, ovr_l);
        end
        // a drop in the same cycle as clr_overrun must win
        for (int i = 0; i < 15; i++)
            tick(0, 1, 1'($urandom), 0, 0);
        tick(0, 1, 1, 0, 1);
        n_cmp++;
        if (ovr_m !== 1'b1 || word_m !== 16'h1111) begin
            n_err++;
            $display("FAIL ovr_priority: got o=%b %h want o=1 1111",
                     ovr_m, word_m);
        end
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        n_cmp++;
        if (val_m !== 1'b0 || ovr_m !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_drain: got v=%b o=%b want 0 0", val_m, ovr_m);
        end
    endtask

    task automatic test_resync();
        logic [15:0] w;
        tick(1, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++)
            tick(0, 1, 1'($urandom), 1, 0);
        tick(1, 1, 1, 1, 0);
        n_cmp++;
        if (cnt_m !== 5'd1 || cnt_l !== 5'd1) begin
            n_err++;
            $display("FAIL resync_count: got %0d/%0d want 1", cnt_m, cnt_l);
        end
        w = 16'($urandom);
        for (int i = 0; i < 15; i++)
            tick(0, 1, w[14-i], 1, 0);
        n_cmp++;
        if (val_m !== 1'b1 || word_m !== {1'b1, w[14:0]}) begin
            n_err++;
            $display("FAIL resync_word: got v=%b %h want v=1 %h",
                     val_m, word_m, {1'b1, w[14:0]});
        end
        n_cmp++;
        if (word_l !== m_wl || word_l[0] !== 1'b1) begin
            n_err++;
            $display("FAIL resync_word_l: got %h want %h", word_l, m_wl);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        tick(1, 0, 0, 0, 0);
        send_word(a, 0);
        for (int i = 0; i < 15; i++)
            tick(0, 1, b[15-i], 0, 0);
        tick(0, 1, b[0], 1, 0);
        n_cmp++;
        if (val_m !== 1'b1 || word_m !== b || ovr_m !== 1'b0) begin
            n_err++;
            $display("FAIL b2b: got v=%b %h o=%b want v=1 %h o=0",
                     val_m, word_m, ovr_m, b);
        end
        tick(0, 0, 0, 1, 0);
        n_cmp++;
        if (val_m !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: got v=%b want 0", val_m);
        end
    endtask

    task automatic test_toggle_and_reset();
        int words = 0;
        int bad = 0;
        logic [15:0] w;
        tick(1, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            w = 16'($urandom);
            for (int i = 0; i < 16; i++) begin
                tick(0, 1, w[15-i], 1, 0);
                if (val_m) begin
                    words++;
                    if (word_m !== w || word_l !== m_wl) bad++;
                end
                tick(0, 0, 0, 1, 0);
            end
        end
        n_cmp++;
        if (words !== 3 || bad !== 0) begin
            n_err++;
            $display("FAIL toggle_words: got %0d (%0d bad) want 3 (0 bad)",
                     words, bad);
        end
        n_cmp++;
        if (ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
            n_err++;
            $display("FAIL toggle_ovr: got %b%b want 00", ovr_m, ovr_l);
        end
        for (int i = 0; i < 5; i++)
            tick(0, 1, 1, 0, 0);
        for (int i = 0; i < 11; i++)
            tick(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            tick(0, 1, 1, 0, 0);
        apply_reset();
        n_cmp++;
        if (val_m !== 1'b0 || cnt_m !== 5'd0 || cnt_l !== 5'd0) begin
            n_err++;
            $display("FAIL midreset: got v=%b c=%0d/%0d want 0 0",
                     val_m, cnt_m, cnt_l);
        end
        release_reset();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 1'($urandom), 1, 0);
            if (val_m || val_l || cnt_m != 0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL postreset_idle: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(19) == 0), ($urandom_range(3) != 0),
                 1'($urandom), 1'($urandom), ($urandom_range(9) == 0));
            if (val_m !== m_valid || val_l !== m_valid ||
                ovr_m !== m_ovr || ovr_l !== m_ovr ||
                word_m !== m_wm || word_l !== m_wl ||
                cnt_m !== 5'(m_bits.size()) || cnt_l !== 5'(m_bits.size()))
            begin
                bad++;
                if (bad < 5)
                    $display("FAIL random@%0d: got v=%b o=%b w=%h/%h c=%0d want v=%b o=%b w=%h/%h c=%0d",
                             i, val_m, ovr_m, word_m, word_l, cnt_m,
                             m_valid, m_ovr, m_wm, m_wl, m_bits.size());
            end
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL random_total: got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_ignore();
        test_msb_first();
        test_lsb_first();
        test_overrun();
        test_resync();
        test_back_to_back();
        test_toggle_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
